weight_fetch_unit: RTL and testbench
====================================

Name: weight_fetch_unit

Overview:
Parametrised weight bus interface. Fetches one output channel's 3x3 and/or 1x1 weight block from memory through the shared arbiter and writes the words in order into the MAC array weight buffer. It generalises fixed-width, single-request weight fetch with three additions: a configurable data width, up to MAX_OUTSTD requests in flight, and a selectable kernel mode. It sits between the accelerator controller and the memory arbiter.

Parameters:
AW, 32, address width (bytes)
DW, 32, data word width; multiple of 8; weights are int8, so DW/8 weights per word
MAX_OUTSTD, 4, maximum requests in flight (power of 2, 1..16)
CNT_W, 12, word-counter width; must hold 9*255

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
weight_start  in  1  one-cycle start pulse; ignored unless in IDLE
weight_done  out  1  one-cycle pulse when the block is fully written
mode  in  2  0: 3x3 then 1x1; 1: 3x3 only; 2: 1x1 only; 3: treated as 0
in_ch  in  8  input channel count, 1..255
out_ch_cnt  in  8  output channel index being fetched
weight3_base_addr  in  AW  3x3 weight region base
weight1_base_addr  in  AW  1x1 weight region base
weight_biu2arb_addr  out  AW  request byte address
weight_biu2arb_vld  out  1  request valid
weight_biu2arb_rdy  in  1  request accepted
arb2weight_biu_addr  in  AW  response address (informational, unused)
arb2weight_biu_data  in  DW  response data
arb2weight_biu_vld  in  1  response valid
arb2weight_biu_rdy  out  1  response ready
weight_waddr  out  CNT_W  MAC buffer word index
weight_wdata  out  DW  MAC buffer data
weight_wen  out  1  MAC buffer write enable

Behaviour:
- Reset (rst_n low at a clk edge): FSM goes to IDLE. All counters are cleared. Every output is 0.
- On weight_start in IDLE, latch mode, in_ch, out_ch_cnt and both bases. Compute:
  - WPW = DW/8
  - W3 = ceil(9*in_ch/WPW)
  - W1 = ceil(in_ch/WPW)
  - A3 = weight3_base_addr + out_ch_cnt*W3*WPW
  - A1 = weight1_base_addr + out_ch_cnt*W1*WPW
  - All address arithmetic is modulo 2^AW.
  - TOTAL = W3+W1 for modes 0/3, W3 for mode 1, W1 for mode 2.
- FSM states: IDLE, REQ3, REQ1, DRAIN, DONE.
  - IDLE -> REQ3 on start (modes 0/1/3); IDLE -> REQ1 on start (mode 2).
  - REQ3 issues A3 + i*WPW for i = 0..W3-1. After the last one is accepted: go to REQ1 (modes 0/3) or DRAIN (mode 1).
  - REQ1 issues A1 + j*WPW for j = 0..W1-1. After the last one is accepted: go to DRAIN.
  - DRAIN waits until the response count reaches TOTAL, then goes to DONE.
  - DONE lasts one cycle with weight_done=1, then returns to IDLE.
- Request handshake:
  - vld is registered. It is asserted in REQ3/REQ1 only while outstanding < MAX_OUTSTD.
  - addr and vld hold stable until rdy is sampled high. A request is accepted on vld&rdy; the address then advances on the next cycle.
  - At most one request per cycle.
- Outstanding counter: +1 on request accept, -1 on response accept. On a simultaneous accept of both it is unchanged. It never exceeds MAX_OUTSTD.
- Response side:
  - arb2weight_biu_rdy = 1 in REQ3, REQ1 and DRAIN; 0 in IDLE and DONE.
  - Responses arrive in request order.
  - On vld&rdy, the next cycle drives weight_wen=1, weight_wdata=data and weight_waddr=rsp_cnt, then rsp_cnt increments. Latency: 1 cycle.
  - 3x3 words occupy waddr 0..W3-1 and 1x1 words occupy W3..TOTAL-1. In mode 2, 1x1 words start at 0.
- weight_done is asserted in the cycle after the final weight_wen. No write occurs in the same cycle as weight_done.
- A response arriving while rdy=0 is not consumed and produces no write.
- weight_start while not in IDLE is ignored; latched parameters are unaffected.
- Reset mid-operation: state is abandoned immediately, with no done pulse. The arbiter shares the same reset, so no stale responses are expected.
- Back-to-back operation: a start in the cycle after DONE (i.e. in IDLE) is accepted.

Test Plan:
1. DW=32, in_ch=4, out_ch_cnt=2, mode=0, bases 0x1000/0x2000, rdy always 1, response returned 2 cycles after accept.
   - Requests: 0x1048, 0x104C, ... 0x1068, then 0x2008.
   - 10 writes with waddr 0..9 and matching data; weight_done one cycle after waddr 9.
2. Same configuration with mode=2.
   - A single request to 0x2008, written at waddr 0, then done.
3. Same configuration with mode=1 and arb rdy low for 5 cycles mid-stream.
   - addr and vld stay stable during the stall; no duplicate or skipped addresses; 9 writes total.
4. MAX_OUTSTD=4, responses withheld for 20 cycles.
   - Exactly 4 requests are accepted, then vld drops.
   - After the responses are released, fetching resumes and all 10 words are written in order.
5. weight_start re-pulsed during REQ3 with in_ch=8.
   - Ignored: still 10 words fetched using in_ch=4 addresses.
6. rst_n low during REQ1 (mode 0).
   - All outputs 0 next cycle; no weight_done.
   - A new start then runs cleanly from waddr 0.

Source files
------------

// File: rtl/weight_fetch_unit.sv
// weight_fetch_unit: fetches one output channel's 3x3 and/or 1x1 weight block
// through the shared arbiter, with up to MAX_OUTSTD requests in flight, and
// writes the returned words in order into the MAC array weight buffer.
module weight_fetch_unit #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int MAX_OUTSTD = 4,
  parameter int CNT_W      = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             weight_start,
  output logic             weight_done,
  input  logic [1:0]       mode,
  input  logic [7:0]       in_ch,
  input  logic [7:0]       out_ch_cnt,
  input  logic [AW-1:0]    weight3_base_addr,
  input  logic [AW-1:0]    weight1_base_addr,
  output logic [AW-1:0]    weight_biu2arb_addr,
  output logic             weight_biu2arb_vld,
  input  logic             weight_biu2arb_rdy,
  input  logic [AW-1:0]    arb2weight_biu_addr,
  input  logic [DW-1:0]    arb2weight_biu_data,
  input  logic             arb2weight_biu_vld,
  output logic             arb2weight_biu_rdy,
  output logic [CNT_W-1:0] weight_waddr,
  output logic [DW-1:0]    weight_wdata,
  output logic             weight_wen
);

  localparam int WPW = DW / 8;                    // int8 weights per bus word
  localparam int OW  = $clog2(MAX_OUTSTD + 1);

  typedef enum logic [2:0] {IDLE, REQ3, REQ1, DRAIN, DONE} state_t;

  // operation parameters captured at start; everything later derives from these
  typedef struct packed {
    logic [1:0]       mode;
    logic [CNT_W-1:0] w3;
    logic [CNT_W-1:0] w1;
    logic [CNT_W-1:0] total;
    logic [AW-1:0]    a1;
  } cfg_t;

  state_t           state, state_nxt;
  cfg_t             cfg;
  logic [CNT_W-1:0] w3_c, w1_c, total_c;
  logic [AW-1:0]    a3_c, a1_c;
  logic [AW-1:0]    addr_q;
  logic             vld_q;
  logic [CNT_W-1:0] req_cnt, phase_words, rsp_cnt;
  logic [OW-1:0]    outst, outst_nxt;
  logic             start_ok, req_acc, rsp_acc, last_req, room_nxt, need1;
  logic             unused_rsp_addr;

  // response address is informational only
  assign unused_rsp_addr = ^arb2weight_biu_addr;

  assign w3_c = CNT_W'((32'(in_ch) * 32'd9 + 32'(WPW) - 32'd1) / 32'(WPW));
  assign w1_c = CNT_W'((32'(in_ch) + 32'(WPW) - 32'd1) / 32'(WPW));
  assign a3_c = weight3_base_addr + AW'(out_ch_cnt) * AW'(w3_c) * AW'(WPW);
  assign a1_c = weight1_base_addr + AW'(out_ch_cnt) * AW'(w1_c) * AW'(WPW);

  // total words to write for the selected kernel mode (3 behaves like 0)
  always_comb begin
    case (mode)
      2'd1:    total_c = w3_c;
      2'd2:    total_c = w1_c;
      default: total_c = w3_c + w1_c;
    endcase
  end

  assign start_ok    = (state == IDLE) && weight_start;
  assign need1       = (cfg.mode != 2'd1);
  assign req_acc     = vld_q && weight_biu2arb_rdy;
  assign rsp_acc     = arb2weight_biu_vld && arb2weight_biu_rdy;
  assign phase_words = (state == REQ3) ? cfg.w3 : cfg.w1;
  assign last_req    = req_acc && (req_cnt == phase_words - CNT_W'(1));
  assign outst_nxt   = outst + OW'(req_acc) - OW'(rsp_acc);
  assign room_nxt    = (outst_nxt < OW'(MAX_OUTSTD));

  assign weight_biu2arb_addr = addr_q;
  assign weight_biu2arb_vld  = vld_q;
  assign arb2weight_biu_rdy  = (state == REQ3) || (state == REQ1) || (state == DRAIN);
  assign weight_done         = (state == DONE);

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (weight_start) state_nxt = (mode == 2'd2) ? REQ1 : REQ3;
      REQ3:  if (last_req)     state_nxt = need1 ? REQ1 : DRAIN;
      REQ1:  if (last_req)     state_nxt = DRAIN;
      DRAIN: if (rsp_cnt == cfg.total) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // latch derived operation parameters on an accepted start
  always_ff @(posedge clk) begin
    if (!rst_n)        cfg <= '0;
    else if (start_ok) cfg <= '{mode: mode, w3: w3_c, w1: w1_c, total: total_c, a1: a1_c};
  end

  // request issue: registered vld/addr, held until accepted, throttled by outstanding count
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q  <= '0;
      vld_q   <= 1'b0;
      req_cnt <= '0;
      outst   <= '0;
    end else begin
      outst <= outst_nxt;
      case (state)
        IDLE: begin
          req_cnt <= '0;
          vld_q   <= weight_start;
          if (weight_start) addr_q <= (mode == 2'd2) ? a1_c : a3_c;
        end
        REQ3, REQ1: begin
          if (last_req) begin
            req_cnt <= '0;
            if (state == REQ3 && need1) begin
              addr_q <= cfg.a1;
              vld_q  <= room_nxt;
            end else begin
              vld_q  <= 1'b0;
            end
          end else begin
            if (req_acc) begin
              addr_q  <= addr_q + AW'(WPW);
              req_cnt <= req_cnt + CNT_W'(1);
            end
            // a pending request keeps room_nxt true, so vld never drops before rdy
            vld_q <= room_nxt;
          end
        end
        default: vld_q <= 1'b0;
      endcase
    end
  end

  // response write-back: one-cycle latency, sequential buffer index
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      weight_wen   <= 1'b0;
      weight_wdata <= '0;
      weight_waddr <= '0;
      rsp_cnt      <= '0;
    end else begin
      weight_wen <= rsp_acc;
      if (rsp_acc) begin
        weight_wdata <= arb2weight_biu_data;
        weight_waddr <= rsp_cnt;
        rsp_cnt      <= rsp_cnt + CNT_W'(1);
      end
      if (start_ok) rsp_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_weight_fetch_unit.sv
// tb_weight_fetch_unit: directed vector table plus hand-written reset and
// restart sequences, against a small in-order arbiter/memory model.
module tb_weight_fetch_unit;
  localparam int AW = 32, DW = 32, CW = 12;
  localparam logic [31:0] K = 32'hA5A5_0000;   // response data = addr ^ K

  logic          clk = 1'b0;
  logic          rst_n;
  logic          weight_start, weight_done;
  logic [1:0]    mode;
  logic [7:0]    in_ch, out_ch_cnt;
  logic [AW-1:0] b3, b1;
  logic [AW-1:0] req_addr;
  logic          req_vld, arb_rdy;
  logic [AW-1:0] rsp_addr;
  logic [DW-1:0] rsp_data;
  logic          rsp_vld, rsp_rdy;
  logic [CW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic          wen;

  weight_fetch_unit #(.AW(AW), .DW(DW), .MAX_OUTSTD(4), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .weight_start(weight_start), .weight_done(weight_done),
    .mode(mode), .in_ch(in_ch), .out_ch_cnt(out_ch_cnt),
    .weight3_base_addr(b3), .weight1_base_addr(b1),
    .weight_biu2arb_addr(req_addr), .weight_biu2arb_vld(req_vld), .weight_biu2arb_rdy(arb_rdy),
    .arb2weight_biu_addr(rsp_addr), .arb2weight_biu_data(rsp_data),
    .arb2weight_biu_vld(rsp_vld), .arb2weight_biu_rdy(rsp_rdy),
    .weight_waddr(waddr), .weight_wdata(wdata), .weight_wen(wen)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  mode;
    int          in_ch;
    int          out_ch;
    logic [31:0] b3, b1;
    bit          stall, hold, restart;
    int          w3, w1;          // words expected from each region
    logic [31:0] a3, a1;          // hand-computed block start addresses
  } vec_t;

  vec_t vecs[9];

  int checks = 0, failures = 0;

  // arbiter model and monitor state
  logic [31:0] q_addr[$];
  int          q_due[$];
  logic [31:0] req_log[$], wa_log[$], wd_log[$];
  int cyc = 0, done_cnt = 0, done_cyc = -100, last_wen_cyc = -1, overlap_cnt = 0;
  int stall_left = 0, hold_left = 0, stab_err = 0, outst = 0, max_outst = 0, hold_reqs = -1;
  bit stall_en = 0, stall_done = 0, hold_vld = 0, prev_pend = 0;
  logic [31:0] prev_addr;

  // arbiter: accepts requests, answers in order 2 cycles later; all handshakes
  // evaluated here see exactly the values present at the following posedge
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      q_addr.delete(); q_due.delete();
      rsp_vld = 1'b0; rsp_addr = '0; rsp_data = '0; arb_rdy = 1'b1;
      outst = 0; prev_pend = 0; stall_left = 0; hold_left = 0;
    end else begin
      if (wen) begin wa_log.push_back(32'(waddr)); wd_log.push_back(wdata); last_wen_cyc = cyc; end
      if (weight_done) begin done_cnt++; done_cyc = cyc; if (wen) overlap_cnt++; end
      if (prev_pend && (!req_vld || req_addr != prev_addr)) stab_err++;
      if (stall_en && !stall_done && req_log.size() >= 3) begin stall_left = 5; stall_done = 1; end
      arb_rdy = (stall_left == 0);
      if (stall_left > 0) stall_left--;
      prev_pend = req_vld && !arb_rdy;
      prev_addr = req_addr;
      if (req_vld && arb_rdy) begin
        req_log.push_back(req_addr); q_addr.push_back(req_addr); q_due.push_back(cyc + 2); outst++;
      end
      if (hold_left > 0) begin
        hold_left--;
        if (hold_left == 0) begin hold_reqs = req_log.size(); hold_vld = req_vld; end
      end
      if (q_addr.size() > 0 && q_due[0] <= cyc && hold_left == 0) begin
        rsp_vld = 1'b1; rsp_addr = q_addr[0]; rsp_data = q_addr[0] ^ K;
      end else begin
        rsp_vld = 1'b0;
      end
      if (rsp_vld && rsp_rdy) begin q_addr.pop_front(); q_due.pop_front(); outst--; end
      if (outst > max_outst) max_outst = outst;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic clear_mon();
    req_log.delete(); wa_log.delete(); wd_log.delete();
    done_cnt = 0; done_cyc = -100; last_wen_cyc = -1; overlap_cnt = 0;
    stab_err = 0; max_outst = 0; hold_reqs = -1; hold_vld = 0; stall_done = 0;
  endtask

  task automatic drive_cfg(input vec_t v);
    mode = v.mode; in_ch = 8'(v.in_ch); out_ch_cnt = 8'(v.out_ch); b3 = v.b3; b1 = v.b1;
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_vld"},   64'(req_vld), 0);
    chk({tag, "_addr"},  64'(req_addr), 0);
    chk({tag, "_rsprdy"},64'(rsp_rdy), 0);
    chk({tag, "_wen"},   64'(wen), 0);
    chk({tag, "_waddr"}, 64'(waddr), 0);
    chk({tag, "_wdata"}, 64'(wdata), 0);
    chk({tag, "_done"},  64'(weight_done), 0);
  endtask

  task automatic run_op(input int idx);
    vec_t v;
    logic [31:0] exp_req[$];
    int t, bad_req, bad_wr;
    v = vecs[idx];
    clear_mon();
    stall_en = v.stall;
    drive_cfg(v);
    weight_start = 1'b1;
    if (v.hold) hold_left = 20;
    tick(1);
    weight_start = 1'b0;
    if (v.restart) begin
      tick(3);
      in_ch = 8'd8; out_ch_cnt = 8'd7; weight_start = 1'b1;
      tick(1);
      weight_start = 1'b0;
    end
    t = 0;
    while (done_cnt == 0 && t < 3000) begin tick(1); t++; end
    tick(3);
    stall_en = 0;
    chk($sformatf("v%0d_done_seen", idx), 64'(done_cnt > 0), 1);
    for (int i = 0; i < v.w3; i++) exp_req.push_back(v.a3 + 32'(4 * i));
    for (int j = 0; j < v.w1; j++) exp_req.push_back(v.a1 + 32'(4 * j));
    chk($sformatf("v%0d_nreq", idx), 64'(req_log.size()), 64'(exp_req.size()));
    chk($sformatf("v%0d_nwr", idx), 64'(wa_log.size()), 64'(exp_req.size()));
    bad_req = 0; bad_wr = 0;
    for (int k = 0; k < exp_req.size(); k++) begin
      if (k < req_log.size() && req_log[k] !== exp_req[k]) bad_req++;
      if (k < wa_log.size() && (wa_log[k] !== 32'(k) || wd_log[k] !== (exp_req[k] ^ K))) bad_wr++;
    end
    chk($sformatf("v%0d_req_addr_errs", idx), 64'(bad_req), 0);
    chk($sformatf("v%0d_write_errs", idx), 64'(bad_wr), 0);
    chk($sformatf("v%0d_done_count", idx), 64'(done_cnt), 1);
    chk($sformatf("v%0d_done_after_last_wen", idx), 64'(done_cyc - last_wen_cyc), 1);
    chk($sformatf("v%0d_wen_with_done", idx), 64'(overlap_cnt), 0);
    chk($sformatf("v%0d_outst_le4", idx), 64'(max_outst <= 4), 1);
    if (v.stall) begin
      chk($sformatf("v%0d_stall_hit", idx), 64'(stall_done), 1);
      chk($sformatf("v%0d_stall_stable_errs", idx), 64'(stab_err), 0);
    end
    if (v.hold) begin
      chk($sformatf("v%0d_hold_reqs", idx), 64'(hold_reqs), 4);
      chk($sformatf("v%0d_hold_vld", idx), 64'(hold_vld), 0);
      chk($sformatf("v%0d_max_outst", idx), 64'(max_outst), 4);
    end
  endtask

  initial begin
    int t;
    //          mode  ic   oc  base3         base1         st hd rs  w3   w1  a3            a1
    vecs[0] = '{2'd0, 4,   2,  32'h1000,     32'h2000,     0, 0, 0,  9,   1,  32'h1048,     32'h2008};
    vecs[1] = '{2'd2, 4,   2,  32'h1000,     32'h2000,     0, 0, 0,  0,   1,  32'h0,        32'h2008};
    vecs[2] = '{2'd1, 4,   2,  32'h1000,     32'h2000,     1, 0, 0,  9,   0,  32'h1048,     32'h0};
    vecs[3] = '{2'd0, 4,   2,  32'h1000,     32'h2000,     0, 1, 0,  9,   1,  32'h1048,     32'h2008};
    vecs[4] = '{2'd0, 4,   2,  32'h1000,     32'h2000,     0, 0, 1,  9,   1,  32'h1048,     32'h2008};
    vecs[5] = '{2'd3, 5,   3,  32'h1000,     32'h2000,     0, 0, 0,  12,  2,  32'h1090,     32'h2018};
    vecs[6] = '{2'd1, 255, 1,  32'h1000,     32'h2000,     0, 0, 0,  574, 0,  32'h18F8,     32'h0};
    vecs[7] = '{2'd2, 8,   3,  32'h1000,     32'hFFFF_FFF0,0, 0, 0,  0,   2,  32'h0,        32'h0000_0008};
    vecs[8] = '{2'd2, 255, 255,32'h1000,     32'h2000,     0, 0, 0,  0,   64, 32'h0,        32'h0001_1F00};

    rst_n = 1'b0; weight_start = 1'b0; mode = '0; in_ch = '0; out_ch_cnt = '0; b3 = '0; b1 = '0;
    tick(3);
    check_outputs_zero("reset");
    rst_n = 1'b1;
    tick(2);

    for (int i = 0; i < 9; i++) begin
      run_op(i);
      tick(2);
    end

    // reset while the 1x1 phase is running: abandon with no done, then rerun cleanly
    clear_mon();
    drive_cfg(vecs[0]);
    weight_start = 1'b1;
    tick(1);
    weight_start = 1'b0;
    t = 0;
    while (req_log.size() < 9 && t < 200) begin tick(1); t++; end
    chk("midrst_reached_req1", 64'(req_log.size() >= 9), 1);
    rst_n = 1'b0;
    tick(1);
    check_outputs_zero("midrst");
    tick(1);
    rst_n = 1'b1;
    tick(5);
    chk("midrst_no_done", 64'(done_cnt), 0);
    run_op(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
